// File: rtl/pc_led_driver.sv
// Stretches pc_monitor[9:7] toggles into PWM-dimmed active-low LED pulses; LED_HEARTBEAT_EN adds an idle green breathing pattern.
// Latency: 2 cycles from pc_monitor to pins/activity; no backpressure, inputs are sampled every cycle.
module pc_led_driver #(
    parameter int PWM_BITS       = 8,
    parameter int STRETCH_CYCLES = 2500000,
    parameter int HB_SHIFT       = 14
) (
    input  logic                clk25,
    input  logic                rst,
    input  logic [15:0]         pc_monitor,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                red_led,
    output logic                green_led,
    output logic                blue_led,
    output logic                activity
);

    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] LOAD = SW'(STRETCH_CYCLES);

    // Channel index 2/1/0 = red/green/blue = pc_monitor bit 9/8/7.
    logic [2:0]          pc_q;
    logic [2:0]          toggle;
    logic [2:0]          live;
    logic [2:0]          on;
    logic [2:0]          pin_d;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SW-1:0]       stretch [3];
    logic                unused_pc;

    assign unused_pc = ^{pc_monitor[15:10], pc_monitor[6:0]};
    assign toggle    = pc_monitor[9:7] ^ pc_q;

    always_comb begin
        live = 3'b000;
        for (int c = 0; c < 3; c++) begin
            live[c] = (stretch[c] != '0);
        end
    end

    assign on = live & {3{pwm_cnt < brightness}};

`ifdef LED_HEARTBEAT_EN
    logic [HB_SHIFT-1:0] hb_pre;
    logic [PWM_BITS:0]   phase;
    logic [PWM_BITS-1:0] level;

    // Top phase bit selects the falling half of the triangle.
    assign level = phase[PWM_BITS] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];

    always_comb begin
        pin_d = ~on;
        if (live == 3'b000) begin
            pin_d    = 3'b111;
            pin_d[1] = ~(pwm_cnt < level);
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            hb_pre <= '0;
            phase  <= '0;
        end else begin
            hb_pre <= hb_pre + HB_SHIFT'(1);
            if (&hb_pre) begin
                phase <= phase + (PWM_BITS+1)'(1);
            end
        end
    end
`else
    localparam int unused_hb_shift = HB_SHIFT;
    assign pin_d = ~on;
`endif

    always_ff @(posedge clk25) begin
        // pc_q tracks the bus even in reset so release never looks like a toggle.
        pc_q <= pc_monitor[9:7];
        if (rst) begin
            pwm_cnt                        <= '0;
            {red_led, green_led, blue_led} <= 3'b111;
            activity                       <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                stretch[c] <= '0;
            end
        end else begin
            pwm_cnt                        <= pwm_cnt + PWM_BITS'(1);
            {red_led, green_led, blue_led} <= pin_d;
            activity                       <= |live;
            for (int c = 0; c < 3; c++) begin
                if (toggle[c]) begin
                    stretch[c] <= LOAD;
                end else if (live[c]) begin
                    stretch[c] <= stretch[c] - SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_led_driver.sv
// Bench for pc_led_driver: edge-indexed reference model plus directed and random scenarios.
module tb_pc_led_driver;

    localparam int PB = 4;
    localparam int SC = 10;
    localparam int HB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   pc = 16'hFFFF;
    logic [PB-1:0] bright = '0;
    logic          red, green, blue, act;

    int cmp = 0;
    int bad = 0;

    pc_led_driver #(.PWM_BITS(PB), .STRETCH_CYCLES(SC), .HB_SHIFT(HB)) dut (
        .clk25(clk), .rst(rst), .pc_monitor(pc), .brightness(bright),
        .red_led(red), .green_led(green), .blue_led(blue), .activity(act)
    );

    always #5 clk = ~clk;

    // Model: n counts edges, r is the last reset edge, live_end[c] is the last edge
    // at which channel c is still live going into the edge (toggle edge + SC).
    int         n = 0;
    int         r = 0;
    int         live_end [3] = '{-100, -100, -100};
    logic [2:0] mpc = 3'b000;
    logic [3:0] exp_v = 4'b1110;

    function automatic logic [3:0] model_out(int m, int rr, int e0, int e1, int e2, logic [PB-1:0] br);
        int k;
        int pwm;
        logic [2:0] lv;
        logic [2:0] lit;
        k   = m - rr - 1;
        pwm = k % (1 << PB);
        lv  = {m <= e2, m <= e1, m <= e0};
        lit = lv & {3{pwm < int'(br)}};
`ifdef LED_HEARTBEAT_EN
        if (lv == 3'b000) begin
            int ph;
            int lvl;
            ph  = (k >> HB) % (1 << (PB + 1));
            lvl = (ph >= (1 << PB)) ? ((1 << PB) - 1 - (ph % (1 << PB))) : ph;
            lit = {1'b0, pwm < lvl, 1'b0};
        end
`endif
        return {~lit, |lv};
    endfunction

    always @(posedge clk) begin
        n   <= n + 1;
        mpc <= pc[9:7];
        if (rst) begin
            r     <= n;
            exp_v <= 4'b1110;
            for (int c = 0; c < 3; c++) live_end[c] <= n;
        end else begin
            exp_v <= model_out(n, r, live_end[0], live_end[1], live_end[2], bright);
            for (int c = 0; c < 3; c++) begin
                if (pc[7 + c] != mpc[c]) live_end[c] <= n + SC;
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmp++;
            if ({red, green, blue, act} !== 4'b1110) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b exp=1110", i, {red, green, blue, act});
            end
        end
    endtask

    task automatic test_single_toggle();
        int act_n = 0;
        bright = 4'hF;
        pc = pc ^ 16'h0100;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            act_n += int'(act);
            cmp++;
            if ({red, green, blue, act} !== exp_v) begin
                bad++;
                $display("FAIL single_toggle cyc=%0d got=%b exp=%b", i, {red, green, blue, act}, exp_v);
            end
        end
        cmp++;
        if (act_n !== SC) begin
            bad++;
            $display("FAIL single_toggle_len got=%0d exp=%0d", act_n, SC);
        end
    endtask

    task automatic test_retrigger();
        int act_n = 0;
        pc = pc ^ 16'h0200;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            act_n += int'(act);
            cmp++;
            if ({red, green, blue, act} !== exp_v) begin
                bad++;
                $display("FAIL retrigger cyc=%0d got=%b exp=%b", i, {red, green, blue, act}, exp_v);
            end
            if (i == 4) pc = pc ^ 16'h0200;
        end
        cmp++;
        if (act_n !== SC + 5) begin
            bad++;
            $display("FAIL retrigger_len got=%0d exp=%0d", act_n, SC + 5);
        end
    endtask

    task automatic test_pwm_duty();
        int low_n = 0;
        bright = 4'd4;
        pc = pc ^ 16'h0080;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 64) low_n += int'(!blue);
            cmp++;
            if ({red, green, blue, act} !== exp_v) begin
                bad++;
                $display("FAIL pwm_duty cyc=%0d got=%b exp=%b", i, {red, green, blue, act}, exp_v);
            end
            if (i % 8 == 7 && i < 56) pc = pc ^ 16'h0080;
        end
        cmp++;
        if (low_n !== 16) begin
            bad++;
            $display("FAIL pwm_duty_count got=%0d exp=16", low_n);
        end
    endtask

    task automatic test_zero_bright_reset();
        bright = '0;
        pc = pc ^ 16'h0200;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cmp++;
            if ({red, green, blue, act} !== exp_v) begin
                bad++;
                $display("FAIL zero_bright cyc=%0d got=%b exp=%b", i, {red, green, blue, act}, exp_v);
            end
            if (i == 1) begin
                cmp++;
                if ({red, act} !== 2'b11) begin
                    bad++;
                    $display("FAIL zero_bright_live got=%b exp=11", {red, act});
                end
            end
            if (i == 3) begin
                cmp++;
                if ({red, green, blue, act} !== 4'b1110) begin
                    bad++;
                    $display("FAIL mid_pulse_reset got=%b exp=1110", {red, green, blue, act});
                end
                rst = 1'b0;
            end
            if (i == 2) rst = 1'b1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            cmp++;
            if ({red, green, blue, act} !== exp_v) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, {red, green, blue, act}, exp_v);
            end
            if ($urandom_range(0, 5) == 0) pc = 16'($urandom);
            if ($urandom_range(0, 20) == 0) bright = PB'($urandom);
            rst = ($urandom_range(0, 60) == 0);
        end
        rst = 1'b0;
    endtask

`ifdef LED_HEARTBEAT_EN
    task automatic test_heartbeat();
        int g_low = 0;
        for (int i = 0; i < 2 * 16 * 4 + 20; i++) begin
            @(negedge clk);
            if (i >= 20) g_low += int'(!green);
            cmp++;
            if ({red, green, blue, act} !== exp_v) begin
                bad++;
                $display("FAIL heartbeat cyc=%0d got=%b exp=%b", i, {red, green, blue, act}, exp_v);
            end
        end
        cmp++;
        if (g_low == 0) begin
            bad++;
            $display("FAIL heartbeat_glow got=%0d exp=nonzero", g_low);
        end
        bright = '0;
        pc = pc ^ 16'h0200;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            cmp++;
            if ({red, green, blue, act} !== exp_v) begin
                bad++;
                $display("FAIL heartbeat_override cyc=%0d got=%b exp=%b", i, {red, green, blue, act}, exp_v);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_toggle();
        test_retrigger();
        test_pwm_duty();
        test_zero_bright_reset();
        test_random();
`ifdef LED_HEARTBEAT_EN
        test_heartbeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
